q_update_engine: RTL and testbench
==================================

Name: q_update_engine

Overview:
- Temporal-difference update stage that consumes the one-hot action chosen by the policy stage.
- Performs one read-modify-write of a Q-table row per request: Q(s,a) <= Q(s,a) + (r + gamma*max Q(s',·) - Q(s,a)) >> ALPHA_SHIFT.
- Sits between the policy stage and the external Q-table RAM; the written row is what the policy stage later reads as its 64-bit Q-value vector.

Parameters:
- STATE_W, 4, state index width; Q-table depth is 2**STATE_W rows.
- ALPHA_SHIFT, 2, learning rate alpha = 2**-ALPHA_SHIFT; legal range 0..8.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- state  in  STATE_W  current state s
- action  in  4  one-hot action a; bit k selects lane k = bits [16k+15:16k]
- next_state  in  STATE_W  next state s'
- reward  in  16  signed reward r
- gamma  in  16  unsigned Q0.16 discount factor
- busy  out  1  high while an update is in flight
- done  out  1  one-cycle pulse, coincident with the write
- err  out  1  one-cycle pulse, request rejected
- mem_addr  out  STATE_W  Q-table address
- mem_rd_en  out  1  read strobe; data valid on mem_rd_data the next cycle
- mem_rd_data  in  64  Q-table row: 4 signed 16-bit lanes
- mem_wr_en  out  1  write strobe
- mem_wr_data  out  64  updated row

Behaviour:
- Reset (async, rst_n=0): FSM to IDLE; busy, done, err, mem_rd_en, mem_wr_en = 0; mem_addr, mem_wr_data = 0; internal registers cleared. Asserting reset mid-update aborts the update; no write occurs.
- FSM states are IDLE, RD_NEXT, RD_CUR, CALC, WRITE.
- IDLE: on start=1, capture state, action, next_state, reward and gamma.
  - If action is not one-hot (0 or more than one bit set): pulse err the next cycle, stay IDLE, no memory access.
  - Otherwise go to RD_NEXT.
- RD_NEXT: mem_rd_en=1, mem_addr=next_state.
- RD_CUR: mem_rd_en=1, mem_addr=state. Register maxQ = signed maximum of the 4 lanes of mem_rd_data. On ties, the value is used; lane identity is irrelevant.
- CALC: mem_rd_data holds the s row; register that row and q_sa = the selected lane. Compute:
  - gmax = (maxQ * {1'b0,gamma}) >>> 16, using a 33-bit signed product; the result floors.
  - td = reward + gmax - q_sa, 18-bit signed, no overflow.
  - delta = td >>> ALPHA_SHIFT (arithmetic shift, floor).
  - qnew = q_sa + delta, 19-bit signed, then reduced to 16 bits per the Optional Feature.
- WRITE: mem_wr_en=1, mem_addr=state, mem_wr_data = captured s row with only the selected lane replaced by qnew. done=1 this cycle; next state IDLE.
- Timing: start accepted in cycle 0 → reads in cycles 1 and 2 → write and done in cycle 4. busy is high in cycles 1 through 4 inclusive. The earliest next accept is cycle 5, so throughput is one update per 5 cycles.
- start while busy is ignored (not queued, no err).
- state == next_state is legal: both reads return the pre-update row, and the write uses it.
- Inputs other than start are don't-care after capture.
- mem_rd_en and mem_wr_en are never high in the same cycle.

Optional Feature:
- Macro: QUPD_SAT_EN.
- Defined: qnew is clamped to [-32768, 32767] before the lane write.
- Undefined: qnew is truncated to its low 16 bits (two's-complement wrap).
- All other behaviour is identical in both builds.

Test Plan:
- Reset: rst_n=0 mid-update (during CALC) → all outputs 0 immediately, no mem_wr_en afterwards, IDLE on release.
- Nominal update, ALPHA_SHIFT=2: s'=3 row lanes {10,40,-5,20}; s=1 row {0,12,0,0}; action=4'b0010, reward=8, gamma=16'h8000.
  - Required: maxQ=40, gmax=20, td=16, delta=4.
  - Write addr 1 with row {0,16,0,0} in cycle 4, done in cycle 4, busy cycles 1–4.
- Negative floor: q_sa=0, reward=-1, next row all 0 → td=-1, delta=-1, lane written -1.
- Overflow: q_sa=32760, reward=32767, next max=32767, gamma=16'hFFFF.
  - Required: gmax=32766, td=32773, delta=8193.
  - QUPD_SAT_EN defined → lane written 32767; undefined → lane written -24583.
- Bad action: start with action=4'b0110, then 4'b0000 → err pulse each time, busy stays 0, no mem_rd_en or mem_wr_en.
- Back-to-back and same-state: start held high for 10 cycles → exactly 2 updates with done in cycles 4 and 9, start ignored while busy; a request with state==next_state uses pre-update values for both reads.

Source files
------------

// File: rtl/q_update_engine_if.sv
// -----------------------------------------------------------------------------
// q_update_engine_if
// Bundles the request handshake from the policy stage and the Q-table RAM bus
// of the TD update engine.
//   Request side : start, state, action (one-hot), next_state, reward, gamma
//   Status side  : busy, done, err
//   RAM side     : mem_addr, mem_rd_en, mem_rd_data, mem_wr_en, mem_wr_data
// Modports:
//   slave  - the update engine (consumes requests, masters the RAM bus)
//   master - the environment (policy stage + Q-table RAM)
// -----------------------------------------------------------------------------
interface q_update_engine_if #(
  parameter int STATE_W = 4
);
  logic                start;
  logic [STATE_W-1:0]  state;
  logic [3:0]          action;
  logic [STATE_W-1:0]  next_state;
  logic signed [15:0]  reward;
  logic [15:0]         gamma;
  logic                busy;
  logic                done;
  logic                err;
  logic [STATE_W-1:0]  mem_addr;
  logic                mem_rd_en;
  logic [63:0]         mem_rd_data;
  logic                mem_wr_en;
  logic [63:0]         mem_wr_data;

  modport slave (
    input  start, state, action, next_state, reward, gamma, mem_rd_data,
    output busy, done, err, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data
  );

  modport master (
    output start, state, action, next_state, reward, gamma, mem_rd_data,
    input  busy, done, err, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data
  );
endinterface

// File: rtl/q_update_engine.sv
// -----------------------------------------------------------------------------
// q_update_engine
// Temporal-difference update of one Q-table row per request:
//   Q(s,a) <= Q(s,a) + (r + gamma*max Q(s',.) - Q(s,a)) >>> ALPHA_SHIFT
// Sequence: IDLE (accept) -> RD_NEXT (read s') -> RD_CUR (read s, take max of
// s' row) -> CALC (s row on the bus, compute new lane) -> WRITE (write, done).
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset; aborts any update in flight
//   bus    - q_update_engine_if.slave (request, status and Q-table RAM bus)
// Parameters:
//   STATE_W     - state index width (Q-table depth 2**STATE_W)
//   ALPHA_SHIFT - learning rate 2**-ALPHA_SHIFT, 0..8
// Build option:
//   QUPD_SAT_EN - when defined the new lane value saturates to 16-bit signed;
//                 otherwise it wraps (keeps the low 16 bits).
// -----------------------------------------------------------------------------
module q_update_engine #(
  parameter int STATE_W     = 4,
  parameter int ALPHA_SHIFT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  q_update_engine_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_NEXT = 3'd1,
    RD_CUR  = 3'd2,
    CALC    = 3'd3,
    WRITE   = 3'd4
  } fsm_t;

  fsm_t                st_q, st_d;
  logic [STATE_W-1:0]  s_q, s_d;
  logic [3:0]          act_q, act_d;
  logic signed [15:0]  rew_q, rew_d;
  logic [15:0]         gam_q, gam_d;
  logic signed [15:0]  max_q_q, max_q_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                rd_en_q, rd_en_d;
  logic                wr_en_q, wr_en_d;
  logic [STATE_W-1:0]  addr_q, addr_d;
  logic [63:0]         wr_data_q, wr_data_d;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic signed [15:0] rd_lane [4];
  logic [63:0]        new_row;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_lane[gi] = $signed(bus.mem_rd_data[16*gi +: 16]);
  end

  // Signed max over the s' row; only the value matters, not which lane won.
  logic signed [15:0] max01, max23, row_max;
  assign max01   = (rd_lane[0] > rd_lane[1]) ? rd_lane[0] : rd_lane[1];
  assign max23   = (rd_lane[2] > rd_lane[3]) ? rd_lane[2] : rd_lane[3];
  assign row_max = (max01 > max23) ? max01 : max23;

  // The captured action is one-hot, so OR-ing its bit pairs yields the lane.
  logic [1:0]         lane_sel;
  logic signed [15:0] q_sa;
  assign lane_sel = {act_q[3] | act_q[2], act_q[3] | act_q[1]};
  assign q_sa     = rd_lane[lane_sel];

  // gamma is unsigned Q0.16: prefix a zero so the signed product is correct.
  // The arithmetic shift floors; the result always fits in 17 bits.
  logic signed [32:0] prod;
  logic signed [16:0] gmax;
  logic signed [17:0] td;
  logic signed [17:0] delta;
  logic signed [18:0] q_new;
  logic signed [15:0] q_new_16;

  assign prod  = max_q_q * $signed({1'b0, gam_q});
  assign gmax  = 17'(prod >>> 16);
  assign td    = 18'(rew_q) + 18'(gmax) - 18'(q_sa);
  assign delta = td >>> ALPHA_SHIFT;
  assign q_new = 19'(q_sa) + 19'(delta);

`ifdef QUPD_SAT_EN
  // Clamp to the 16-bit signed range: bits [18:15] must all agree to fit.
  always_comb begin
    if (!q_new[18] && (q_new[17:15] != 3'b000)) begin
      q_new_16 = 16'sh7FFF;
    end else if (q_new[18] && (q_new[17:15] != 3'b111)) begin
      q_new_16 = 16'sh8000;
    end else begin
      q_new_16 = 16'(q_new);
    end
  end
`else
  // Two's-complement wrap: keep the low 16 bits.
  assign q_new_16 = 16'(q_new);
`endif

  // Only the selected lane is replaced; the rest of the s row passes through.
  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign new_row[16*gi +: 16] = act_q[gi] ? q_new_16 : bus.mem_rd_data[16*gi +: 16];
  end

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    st_d      = st_q;
    s_d       = s_q;
    act_d     = act_q;
    rew_d     = rew_q;
    gam_d     = gam_q;
    max_q_d   = max_q_q;
    busy_d    = busy_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    // Strobes and status pulses last one cycle unless re-asserted below.
    done_d    = 1'b0;
    err_d     = 1'b0;
    rd_en_d   = 1'b0;
    wr_en_d   = 1'b0;

    unique case (st_q)
      IDLE: begin
        if (bus.start) begin
          s_d   = bus.state;
          act_d = bus.action;
          rew_d = bus.reward;
          gam_d = bus.gamma;
          if ($onehot(bus.action)) begin
            st_d    = RD_NEXT;
            busy_d  = 1'b1;
            rd_en_d = 1'b1;
            addr_d  = bus.next_state;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RD_NEXT: begin
        st_d    = RD_CUR;
        rd_en_d = 1'b1;
        addr_d  = s_q;
      end
      RD_CUR: begin
        // s' row is on the bus now.
        max_q_d = row_max;
        st_d    = CALC;
      end
      CALC: begin
        // s row is on the bus now; the merged row is registered for the write.
        wr_data_d = new_row;
        wr_en_d   = 1'b1;
        done_d    = 1'b1;
        addr_d    = s_q;
        st_d      = WRITE;
      end
      WRITE: begin
        busy_d = 1'b0;
        st_d   = IDLE;
      end
      default: begin
        busy_d = 1'b0;
        st_d   = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= IDLE;
      s_q       <= '0;
      act_q     <= '0;
      rew_q     <= '0;
      gam_q     <= '0;
      max_q_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
    end else begin
      st_q      <= st_d;
      s_q       <= s_d;
      act_q     <= act_d;
      rew_q     <= rew_d;
      gam_q     <= gam_d;
      max_q_q   <= max_q_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_rd_en   = rd_en_q;
  assign bus.mem_wr_en   = wr_en_q;
  assign bus.mem_wr_data = wr_data_q;

endmodule

// File: tb/tb_q_update_engine.sv
// -----------------------------------------------------------------------------
// tb_q_update_engine
// Drives q_update_engine through its interface with directed and randomized
// requests. A Q-table RAM model answers the engine's reads one cycle after
// mem_rd_en. A reference model computes each update from the TD rule with
// plain integer arithmetic and predicts the cycle-by-cycle outputs, which are
// compared on every falling clock edge. Build option QUPD_SAT_EN selects the
// saturating expectation.
// -----------------------------------------------------------------------------
module tb_q_update_engine;
  localparam int STATE_W     = 4;
  localparam int ALPHA_SHIFT = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  q_update_engine_if #(.STATE_W(STATE_W)) bus();

  q_update_engine #(
    .STATE_W    (STATE_W),
    .ALPHA_SHIFT(ALPHA_SHIFT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- Q-table RAM ----------------
  logic [63:0]        ram [16];
  logic               pre_en = 1'b0;
  logic [STATE_W-1:0] pre_addr = '0;
  logic [63:0]        pre_data = '0;

  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= ram[bus.mem_addr];
    if (bus.mem_wr_en) ram[bus.mem_addr] <= bus.mem_wr_data;
    if (pre_en)        ram[pre_addr] <= pre_data;
  end

  // ---------------- Reference model ----------------
  logic [63:0] model_q [16];

  function automatic logic [63:0] row4(int l0, int l1, int l2, int l3);
    return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
  endfunction

  function automatic logic [15:0] lane_of(logic [63:0] row, int k);
    return row[16*k +: 16];
  endfunction

  // New s row from the TD rule, using integer arithmetic.
  function automatic logic [63:0] td_update(logic [63:0] ns_row, logic [63:0] s_row,
                                            logic [3:0] act, logic signed [15:0] r,
                                            logic [15:0] g);
    longint maxq, v, gm, qsa, tdv, dl, qn;
    int     lane;
    logic [63:0] res;
    maxq = -32768;
    for (int k = 0; k < 4; k++) begin
      v = longint'($signed(ns_row[16*k +: 16]));
      if (v > maxq) maxq = v;
    end
    lane = 0;
    for (int k = 0; k < 4; k++) if (act[k]) lane = k;
    qsa = longint'($signed(s_row[16*lane +: 16]));
    gm  = (maxq * longint'({48'd0, g})) >>> 16;   // floor
    tdv = longint'(r) + gm - qsa;
    dl  = tdv >>> ALPHA_SHIFT;                     // floor
    qn  = qsa + dl;
`ifdef QUPD_SAT_EN
    if (qn > 32767)  qn = 32767;
    if (qn < -32768) qn = -32768;
`endif
    res = s_row;
    res[16*lane +: 16] = 16'(qn);
    return res;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- Per-cycle compare process ----------------
  // phase = cycles since the accepting cycle (0 when no update in flight).
  int                 phase = 0;
  logic               exp_err = 1'b0;
  logic [STATE_W-1:0] exp_s = '0, exp_ns = '0;
  logic [63:0]        exp_row = '0;
  int                 err_cnt = 0, rd_cnt = 0, wr_cnt = 0;
  int                 done_cycs[$];
  logic [63:0]        done_rows[$];
  logic [STATE_W-1:0] done_addrs[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy",  64'(bus.busy),      64'd0);
      chk("rst_done",  64'(bus.done),      64'd0);
      chk("rst_err",   64'(bus.err),       64'd0);
      chk("rst_rd_en", 64'(bus.mem_rd_en), 64'd0);
      chk("rst_wr_en", 64'(bus.mem_wr_en), 64'd0);
      chk("rst_addr",  64'(bus.mem_addr),  64'd0);
      chk("rst_wdata", bus.mem_wr_data,    64'd0);
      phase   = 0;
      exp_err = 1'b0;
    end else begin
      chk("busy",  64'(bus.busy),      64'(phase >= 1));
      chk("rd_en", 64'(bus.mem_rd_en), 64'(phase == 1 || phase == 2));
      chk("wr_en", 64'(bus.mem_wr_en), 64'(phase == 4));
      chk("done",  64'(bus.done),      64'(phase == 4));
      chk("err",   64'(bus.err),       64'(exp_err));
      if (phase == 1) chk("rd_addr_next", 64'(bus.mem_addr), 64'(exp_ns));
      if (phase == 2) chk("rd_addr_cur",  64'(bus.mem_addr), 64'(exp_s));
      if (phase == 4) begin
        chk("wr_addr", 64'(bus.mem_addr), 64'(exp_s));
        chk("wr_data", bus.mem_wr_data,   exp_row);
        model_q[exp_s] = exp_row;
      end
      if (bus.done) begin
        done_cycs.push_back(cyc);
        done_rows.push_back(bus.mem_wr_data);
        done_addrs.push_back(bus.mem_addr);
      end
      if (bus.err)       err_cnt++;
      if (bus.mem_rd_en) rd_cnt++;
      if (bus.mem_wr_en) wr_cnt++;

      exp_err = 1'b0;
      if (phase == 0) begin
        if (bus.start) begin
          if ($countones(bus.action) == 1) begin
            phase   = 1;
            exp_s   = bus.state;
            exp_ns  = bus.next_state;
            exp_row = td_update(model_q[bus.next_state], model_q[bus.state],
                                bus.action, bus.reward, bus.gamma);
          end else begin
            exp_err = 1'b1;
          end
        end
      end else if (phase == 4) begin
        phase = 0;
      end else begin
        phase = phase + 1;
      end
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [STATE_W-1:0] a, input logic [63:0] d);
    pre_en   = 1'b1;
    pre_addr = a;
    pre_data = d;
    model_q[a] = d;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic drive_req(input logic [STATE_W-1:0] s, input logic [STATE_W-1:0] ns,
                           input logic [3:0] a, input logic signed [15:0] r,
                           input logic [15:0] g);
    bus.state      = s;
    bus.next_state = ns;
    bus.action     = a;
    bus.reward     = r;
    bus.gamma      = g;
  endtask

  // Waits (bounded) until done is visible just after a rising edge.
  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (bus.done !== 1'b1) begin
      fails++;
      $display("FAIL %s_timeout: got no done expected done within 20 cycles", name);
    end
  endtask

  int          c0, e0, r0, w0;
  int          nd;
  logic [63:0] rnd_row;

  initial begin
    bus.start      = 1'b0;
    bus.state      = '0;
    bus.next_state = '0;
    bus.action     = '0;
    bus.reward     = '0;
    bus.gamma      = '0;
    bus.mem_rd_data = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) preload(4'(i), 64'd0);

    // ---- Nominal update ----
    preload(4'd3, row4(10, 40, -5, 20));
    preload(4'd1, row4(0, 12, 0, 0));
    drive_req(4'd1, 4'd3, 4'b0010, 16'sd8, 16'h8000);
    bus.start = 1'b1;
    c0 = cyc;
    tick();
    bus.start = 1'b0;
    wait_done("nominal");
    chk("nominal_cycle", 64'(cyc), 64'(c0 + 4));
    chk("nominal_addr",  64'(bus.mem_addr), 64'd1);
    chk("nominal_row",   bus.mem_wr_data, 64'h0000_0000_0010_0000);
    tick();

    // ---- Negative floor ----
    preload(4'd7, 64'd0);
    preload(4'd2, 64'd0);
    drive_req(4'd2, 4'd7, 4'b0001, -16'sd1, 16'($urandom_range(0, 65535)));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done("negfloor");
    chk("negfloor_lane", 64'(lane_of(bus.mem_wr_data, 0)), 64'(16'hFFFF));
    tick();

    // ---- Overflow ----
    preload(4'd9, row4(32767, 0, 0, 0));
    preload(4'd4, row4(0, 0, 32760, 0));
    drive_req(4'd4, 4'd9, 4'b0100, 16'sd32767, 16'hFFFF);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done("overflow");
`ifdef QUPD_SAT_EN
    chk("overflow_lane_sat",  64'(lane_of(bus.mem_wr_data, 2)), 64'(16'h7FFF));
`else
    chk("overflow_lane_wrap", 64'(lane_of(bus.mem_wr_data, 2)), 64'(16'h9FF9));
`endif
    tick();

    // ---- Bad actions ----
    e0 = err_cnt; r0 = rd_cnt; w0 = wr_cnt;
    drive_req(4'd1, 4'd3, 4'b0110, 16'sd5, 16'h4000);
    bus.start = 1'b1;
    tick();
    bus.action = 4'b0000;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    chk("badact_err_pulses", 64'(err_cnt - e0), 64'd2);
    chk("badact_no_reads",   64'(rd_cnt - r0),  64'd0);
    chk("badact_no_writes",  64'(wr_cnt - w0),  64'd0);

    // ---- Back-to-back, same state ----
    preload(4'd5, row4(100, 0, 0, 0));
    nd = done_cycs.size();
    drive_req(4'd5, 4'd5, 4'b0001, 16'sd0, 16'h8000);
    bus.start = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 10; i++) tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    chk("b2b_done_count", 64'(done_cycs.size() - nd), 64'd2);
    if (done_cycs.size() - nd == 2) begin
      chk("b2b_done1_cycle", 64'(done_cycs[nd]),     64'(c0 + 4));
      chk("b2b_done2_cycle", 64'(done_cycs[nd + 1]), 64'(c0 + 9));
      chk("b2b_lane_first",  64'(lane_of(done_rows[nd], 0)),     64'(16'd87));
      chk("b2b_lane_second", 64'(lane_of(done_rows[nd + 1], 0)), 64'(16'd76));
      chk("b2b_addr",        64'(done_addrs[nd + 1]),            64'd5);
    end

    // ---- Reset during CALC ----
    preload(4'd6, row4(0, 0, 0, 50));
    preload(4'd8, row4(1, 2, 3, 4));
    w0 = wr_cnt;
    drive_req(4'd6, 4'd8, 4'b1000, 16'sd100, 16'h8000);
    bus.start = 1'b1;
    tick();                 // cycle 1
    bus.start = 1'b0;
    tick();                 // cycle 2
    tick();                 // cycle 3 (CALC)
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",  64'(bus.busy),      64'd0);
    chk("midrst_rd_en", 64'(bus.mem_rd_en), 64'd0);
    chk("midrst_wr_en", 64'(bus.mem_wr_en), 64'd0);
    chk("midrst_done",  64'(bus.done),      64'd0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("midrst_no_write", 64'(wr_cnt - w0), 64'd0);
    chk("midrst_row_kept", ram[6], row4(0, 0, 0, 50));

    // ---- Randomized traffic ----
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 5))
          0:       rnd_row[16*k +: 16] = 16'h7FFF;
          1:       rnd_row[16*k +: 16] = 16'h8000;
          default: rnd_row[16*k +: 16] = 16'($urandom);
        endcase
      end
      preload(4'(i), rnd_row);
    end
    for (int i = 0; i < 600; i++) begin
      bus.start      = ($urandom_range(0, 9) < 4);
      bus.state      = 4'($urandom_range(0, 15));
      bus.next_state = ($urandom_range(0, 3) == 0) ? bus.state : 4'($urandom_range(0, 15));
      bus.action     = ($urandom_range(0, 4) != 0) ? 4'(1 << $urandom_range(0, 3))
                                                   : 4'($urandom);
      bus.reward     = ($urandom_range(0, 7) == 0) ? 16'sh7FFF : 16'($urandom);
      bus.gamma      = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      tick();
    end
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
